blk_transpose: RTL
==================

# blk_transpose

Block transpose stage between `hdmi_to_blocks` and the column pass of the 2-D DCT. It takes 8x8 blocks of Y/Cr/Cb samples in row-major order, N samples per beat. It re-emits each block in column-major order with regenerated sob/eob/sof framing. A two-bank ping-pong register store sustains full input throughput with no back-pressure.

## Interface
- `N`, default 2: samples per beat; must divide 8. B = 64/N beats per block, R = 8/N beats per row.
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset; clock clk
- `in_valid`  in  1  input beat qualifier
- `in_data_y`, `in_data_cr`, `in_data_cb`  in  signed [N-1:0][7:0] each  row-major samples; lane i = column N*k+i of current row
- `in_sob`  in  1  first beat of a block (qualified by in_valid)
- `in_eob`  in  1  last beat of a block (informational; not used for counting)
- `in_sof`  in  1  first beat of first block of a frame
- `out_valid`  out  1  output beat qualifier
- `out_data_y`, `out_data_cr`, `out_data_cb`  out  signed [N-1:0][7:0] each  column-major samples; lane i = row N*j+i of current column
- `out_sob`, `out_eob`, `out_sof`  out  1 each  framing, each qualified by out_valid
- `err_sync`  out  1  one-cycle pulse on framing error

## Operation
- Storage: two banks of 64 x 24-bit registers (cb,cr,y per sample), flops not RAM. N rows must be read per beat, so RAM is not used.
- Write side: counter wcnt 0..B-1 advances on each in_valid beat.
  - Beat wcnt writes samples to row = wcnt / R, columns N*(wcnt mod R)+i of bank wsel.
  - The bank's sof flag is captured from in_sof on the beat with wcnt=0.
- When wcnt=B-1 is written: wcnt wraps to 0, wsel toggles, and the completed bank is marked full.
- Read side FSM: IDLE, then READ.
  - IDLE -> READ on a full flag; rsel is set to the full bank.
  - READ emits one beat per cycle unconditionally. Counter rcnt 0..B-1 selects column c = rcnt / R and row group j = rcnt mod R.
  - At rcnt=B-1 the bank's full flag clears. The FSM goes back to IDLE, or stays in READ if the other bank is already full, which gives back-to-back output.
- Bank collision cannot occur: a bank refills in at least B cycles and is drained in exactly B cycles starting one cycle after it fills.
- Resync: in_valid && in_sob with wcnt != 0 causes these actions:
  - the partial block is discarded;
  - this beat is written as beat 0;
  - err_sync pulses the next cycle.
- in_valid && !in_sob with wcnt=0 is accepted as beat 0 with no error.
- Out data is a straight copy: no arithmetic, no sign change, no rounding.
- Framing on output: sob at rcnt=0, eob at rcnt=B-1, sof at rcnt=0 when the bank's sof flag is set.
- Reset, including mid-block: wcnt, rcnt, wsel, rsel and full flags clear; FSM goes to IDLE. Any partial or unread block is lost and bank contents need not be cleared.

## Timing
- Reset values: out_valid, out_sob, out_eob, out_sof, err_sync, and all out_data lanes are 0.
- All outputs are registered. Out data holds its last value when out_valid=0.
- Last input beat written in cycle t, so the full flag is visible in t+1.
- The output beats follow from that:
  - out_valid is high on cycles t+2 .. t+1+B, contiguous regardless of input gaps.
  - Latency from last input beat to first output beat is 2 cycles.
- Continuous input gives continuous output with out_valid never dropping, and every block delayed by B+1 cycles.
- Simultaneous events in one cycle:
  - write completes bank A and read finishes bank B: A is selected next with no bubble;
  - resync and completion in the same cycle: impossible by construction.
- err_sync is a 1-cycle pulse, registered.

## Test plan
- Single block, N=2, Y sample (r,c) = 8r+c, Cr = -(8r+c), Cb = 0x40+r: the sequence below is required.
  - 32 output beats starting 2 cycles after the last input beat.
  - Beat m has Y lanes {8*(2*(m mod 4))+m/4, 8*(2*(m mod 4)+1)+m/4}; matching Cr/Cb.
  - sob on beat 0, eob on beat 31.
- Five blocks back-to-back, in_valid constant: out_valid high continuously for 160 cycles, each block correctly transposed, 5 sob and 5 eob pulses.
- Input with in_valid at 50% random duty: each output block is still 32 contiguous beats, with content identical to the gap-free case.
- in_sof on the first block of frame 2 only: out_sof fires exactly once, on beat 0 of that block's output.
- in_sob asserted at wcnt=13: err_sync pulses once and the partial block never appears. The next 32 beats form a correct block.
- rst_n low for 1 cycle at wcnt=20 with a read in progress: outputs go to 0 immediately. Afterwards the first complete block is output correctly and no stale beat appears.

Source files
------------

// File: rtl/blk_transpose.sv
// -----------------------------------------------------------------------------
// blk_transpose
//   Block transpose stage between hdmi_to_blocks and the column pass of the
//   2-D DCT. Accepts 8x8 Y/Cr/Cb blocks in row-major order, N samples per
//   beat, and re-emits each block in column-major order with regenerated
//   sob/eob/sof framing. Two ping-pong banks of flops let a new block be
//   written while the previous one is read, so no back-pressure is needed.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid                input beat qualifier
//   in_data_y/cr/cb         N lanes x 8 bit, lane i = column N*k+i of the row
//   in_sob/in_eob/in_sof    input framing (in_eob is informational only)
//   out_valid               output beat qualifier
//   out_data_y/cr/cb        N lanes x 8 bit, lane i = row N*j+i of the column
//   out_sob/out_eob/out_sof output framing, qualified by out_valid
//   err_sync                one-cycle pulse when in_sob arrives mid-block
// -----------------------------------------------------------------------------
module blk_transpose #(
    parameter int N = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [N-1:0][7:0] in_data_y,
    input  logic signed [N-1:0][7:0] in_data_cr,
    input  logic signed [N-1:0][7:0] in_data_cb,
    input  logic                    in_sob,
    input  logic                    in_eob,
    input  logic                    in_sof,
    output logic                    out_valid,
    output logic signed [N-1:0][7:0] out_data_y,
    output logic signed [N-1:0][7:0] out_data_cr,
    output logic signed [N-1:0][7:0] out_data_cb,
    output logic                    out_sob,
    output logic                    out_eob,
    output logic                    out_sof,
    output logic                    err_sync
);

    localparam int unsigned NU   = N;
    localparam int unsigned B    = 64 / NU;
    localparam int unsigned R    = 8 / NU;
    localparam int unsigned CW   = $clog2(B);
    localparam logic [CW-1:0] LAST = CW'(B - 1);

    typedef enum logic {IDLE, READ} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic [CW-1:0]   rcnt_q, rcnt_d;
    logic            wsel_q, wsel_d;
    logic            rsel_q, rsel_d;
    logic [1:0]      full_q, full_d;
    logic [1:0]      sof_bank_q, sof_bank_d;
    logic [1:0]      full_set, full_clr;
    logic [23:0]     mem_q [2][64];
    logic [23:0]     mem_d [2][64];

    logic            out_valid_q, out_valid_d;
    logic            out_sob_q, out_sob_d;
    logic            out_eob_q, out_eob_d;
    logic            out_sof_q, out_sof_d;
    logic            err_q, err_d;
    logic [N-1:0][7:0] out_y_q, out_y_d;
    logic [N-1:0][7:0] out_cr_q, out_cr_d;
    logic [N-1:0][7:0] out_cb_q, out_cb_d;

    logic            resync;
    logic [CW-1:0]   wbeat;
    int unsigned     wb;
    int unsigned     rb;
    logic            emit;
    logic            bank;

    // in_eob carries no information the beat counter does not already have.
    logic unused_eob;
    assign unused_eob = in_eob;

    // ---------------------------------------------------------------- write side
    // A sob in the middle of a block restarts the write at beat 0 of the same
    // bank; the partial contents are simply overwritten.
    assign resync = in_valid && in_sob && (wcnt_q != '0);
    assign wbeat  = resync ? '0 : wcnt_q;

    always_comb begin
        mem_d      = mem_q;
        wcnt_d     = wcnt_q;
        wsel_d     = wsel_q;
        sof_bank_d = sof_bank_q;
        full_set   = '0;
        err_d      = resync;
        wb         = 32'(wbeat);
        if (in_valid) begin
            for (int unsigned i = 0; i < NU; i++) begin
                mem_d[wsel_q][6'((wb / R) * 8 + NU * (wb % R) + i)] =
                    {in_data_cb[i], in_data_cr[i], in_data_y[i]};
            end
            if (wbeat == '0) begin
                sof_bank_d[wsel_q] = in_sof;
            end
            if (wbeat == LAST) begin
                wcnt_d           = '0;
                wsel_d           = ~wsel_q;
                full_set[wsel_q] = 1'b1;
            end else begin
                wcnt_d = wbeat + CW'(1);
            end
        end
    end

    // ----------------------------------------------------------------- read side
    // The first beat is produced already in IDLE, in the cycle the full flag
    // becomes visible, so the output starts two cycles after the last input.
    always_comb begin
        state_d     = state_q;
        rsel_d      = rsel_q;
        rcnt_d      = rcnt_q;
        full_clr    = '0;
        out_valid_d = 1'b0;
        out_sob_d   = 1'b0;
        out_eob_d   = 1'b0;
        out_sof_d   = 1'b0;
        out_y_d     = out_y_q;
        out_cr_d    = out_cr_q;
        out_cb_d    = out_cb_q;
        emit        = 1'b0;
        bank        = rsel_q;
        rb          = 32'(rcnt_q);

        case (state_q)
            IDLE: begin
                if (|full_q) begin
                    emit = 1'b1;
                    // Prefer the older bank should both ever be full.
                    bank = full_q[wsel_q] ? wsel_q : ~wsel_q;
                end
            end
            READ: emit = 1'b1;
            default: ;
        endcase

        if (emit) begin
            for (int unsigned i = 0; i < NU; i++) begin
                {out_cb_d[i], out_cr_d[i], out_y_d[i]} =
                    mem_q[bank][6'((NU * (rb % R) + i) * 8 + rb / R)];
            end
            out_valid_d = 1'b1;
            out_sob_d   = (rcnt_q == '0);
            out_eob_d   = (rcnt_q == LAST);
            out_sof_d   = (rcnt_q == '0) && sof_bank_q[bank];
            if (rcnt_q == LAST) begin
                full_clr[bank] = 1'b1;
                rcnt_d         = '0;
                if (full_q[~bank]) begin
                    state_d = READ;
                    rsel_d  = ~bank;
                end else begin
                    state_d = IDLE;
                end
            end else begin
                rcnt_d  = rcnt_q + CW'(1);
                state_d = READ;
                rsel_d  = bank;
            end
        end
    end

    assign full_d = (full_q & ~full_clr) | full_set;

    // ------------------------------------------------------------------ registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            wsel_q      <= 1'b0;
            rsel_q      <= 1'b0;
            full_q      <= '0;
            sof_bank_q  <= '0;
            out_valid_q <= 1'b0;
            out_sob_q   <= 1'b0;
            out_eob_q   <= 1'b0;
            out_sof_q   <= 1'b0;
            err_q       <= 1'b0;
            out_y_q     <= '0;
            out_cr_q    <= '0;
            out_cb_q    <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            wsel_q      <= wsel_d;
            rsel_q      <= rsel_d;
            full_q      <= full_d;
            sof_bank_q  <= sof_bank_d;
            out_valid_q <= out_valid_d;
            out_sob_q   <= out_sob_d;
            out_eob_q   <= out_eob_d;
            out_sof_q   <= out_sof_d;
            err_q       <= err_d;
            out_y_q     <= out_y_d;
            out_cr_q    <= out_cr_d;
            out_cb_q    <= out_cb_d;
        end
    end

    // Bank contents are never reset; they are always written before being read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign out_valid   = out_valid_q;
    assign out_sob     = out_sob_q;
    assign out_eob     = out_eob_q;
    assign out_sof     = out_sof_q;
    assign err_sync    = err_q;
    assign out_data_y  = out_y_q;
    assign out_data_cr = out_cr_q;
    assign out_data_cb = out_cb_q;

endmodule
